// File: rtl/buzz_arb_pkg.sv
// Shared types and helpers for the Buzz share arbiter.
package buzz_arb_pkg;

  localparam int unsigned DEF_N     = 2;
  localparam int unsigned DEF_WIDTH = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Down-counter width for the Buzz latency wait; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat == 0) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/buzz_rr_pick.sv
// Combinational round-robin picker: first set bit at or after ptr, wrapping modulo N.
module buzz_rr_pick
  import buzz_arb_pkg::*;
#(
  parameter int unsigned N  = DEF_N,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [PW:0] k;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    k      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      k = {1'b0, ptr} + (PW+1)'(i);
      if (k >= (PW+1)'(N)) k = k - (PW+1)'(N);
      if (!any && req[k[PW-1:0]]) begin
        any            = 1'b1;
        idx            = k[PW-1:0];
        onehot[k[PW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/buzz_share_arbiter.sv
// Time-shares one external Buzz unit among N requesters, round-robin.
// Optional BUZZ_ARB_CHAIN_EN adds chain_sel: feed the previous Buzz result back in.
module buzz_share_arbiter
  import buzz_arb_pkg::*;
#(
  parameter int unsigned N            = DEF_N,
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned BUZZ_LATENCY = 0
) (
  input  logic               CLK,
  input  logic               ASYNCRESETN,
  input  logic [N-1:0]       req_valid,
  input  logic [N*WIDTH-1:0] req_I,
  output logic [N-1:0]       req_ready,
  output logic [N-1:0]       resp_valid,
  output logic [WIDTH-1:0]   resp_O,
  output logic [WIDTH-1:0]   buzz_I,
  input  logic [WIDTH-1:0]   buzz_O,
`ifdef BUZZ_ARB_CHAIN_EN
  input  logic [N-1:0]       chain_sel,
`endif
  output logic               busy
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = cnt_width(BUZZ_LATENCY);

  state_t             state_q;
  logic [PW-1:0]      rr_ptr_q;
  logic [PW-1:0]      grant_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   buzz_I_q;
  logic [WIDTH-1:0]   resp_O_q;
  logic [N-1:0]       resp_valid_q;
  logic               busy_q;
  logic [WIDTH-1:0]   operand_d;

  logic [N-1:0]       pick_onehot;
  logic [PW-1:0]      pick_idx;
  logic               pick_any;
  logic [WIDTH-1:0]   req_arr [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign req_arr[g] = req_I[g*WIDTH +: WIDTH];
  end

  buzz_rr_pick #(.N(N)) u_pick (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

`ifdef BUZZ_ARB_CHAIN_EN
  logic [WIDTH-1:0] last_O_q;

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN)          last_O_q <= '0;
    else if (state_q == RESP)  last_O_q <= resp_O_q;
  end

  assign operand_d = chain_sel[pick_idx] ? last_O_q : req_arr[pick_idx];
`else
  assign operand_d = req_arr[pick_idx];
`endif

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      cnt_q        <= '0;
      buzz_I_q     <= '0;
      resp_O_q     <= '0;
      resp_valid_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_any) begin
            buzz_I_q <= operand_d;
            grant_q  <= pick_idx;
            cnt_q    <= CW'(BUZZ_LATENCY);
            busy_q   <= 1'b1;
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            resp_O_q     <= buzz_O;
            resp_valid_q <= N'(1) << grant_q;
            state_q      <= RESP;
          end
        end
        RESP: begin
          // Pointer moves only on completion, so withdrawn requests cost nothing.
          resp_valid_q <= '0;
          busy_q       <= 1'b0;
          rr_ptr_q     <= (grant_q == PW'(N-1)) ? '0 : grant_q + 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE) ? pick_onehot : '0;
  assign resp_valid = resp_valid_q;
  assign resp_O     = resp_O_q;
  assign buzz_I     = buzz_I_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_buzz_share_arbiter.sv
// Randomized bench for buzz_share_arbiter (N=3, WIDTH=8, 2-stage Buzz) with a transaction-level model.
module tb_buzz_share_arbiter;

  localparam int unsigned N = 3;
  localparam int unsigned W = 8;
  localparam int unsigned L = 2;

  logic           CLK = 1'b0;
  logic           ASYNCRESETN = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_I = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_O;
  logic [W-1:0]   buzz_I;
  logic [W-1:0]   buzz_O;
  logic           busy;
`ifdef BUZZ_ARB_CHAIN_EN
  logic [N-1:0]   chain_sel = '0;
`endif

  logic [W-1:0]   bz1, bz2;

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level model state.
  logic [N-1:0]   pend = '0;
  logic [W-1:0]   dat [N];
  bit             m_act = 0;
  int unsigned    m_k = 0;
  int unsigned    m_g = 0;
  int unsigned    m_ptr = 0;
  logic [W-1:0]   m_data = '0;
  logic [W-1:0]   m_buzzI = '0;
  logic [W-1:0]   m_respO = '0;

  buzz_share_arbiter #(.N(N), .WIDTH(W), .BUZZ_LATENCY(L)) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .req_valid   (req_valid),
    .req_I       (req_I),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_O      (resp_O),
    .buzz_I      (buzz_I),
    .buzz_O      (buzz_O),
`ifdef BUZZ_ARB_CHAIN_EN
    .chain_sel   (chain_sel),
`endif
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] buzz_fn(input logic [W-1:0] x);
    return {x[W-2:0], x[W-1]} ^ 8'h5A;
  endfunction

  always @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      bz1 <= '0;
      bz2 <= '0;
    end else begin
      bz1 <= buzz_fn(buzz_I);
      bz2 <= bz1;
    end
  end
  assign buzz_O = bz2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req_valid = pend;
    for (int i = 0; i < N; i++) req_I[i*W +: W] = dat[i];
  endtask

  // One clock cycle: called at the falling edge with inputs already driven.
  task automatic cycle();
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_resp;
    bit           exp_busy;
    bit           idle;
    bit           found;
    int unsigned  win;
    #1;
    if (m_act && m_k == L + 3) m_act = 0;
    idle      = !m_act;
    exp_busy  = m_act && m_k >= 1 && m_k <= L + 2;
    exp_resp  = '0;
    if (m_act && m_k == L + 2) begin
      exp_resp = N'(1) << m_g;
      m_respO  = buzz_fn(m_data);
    end
    exp_ready = '0;
    found = 0;
    win   = 0;
    if (idle) begin
      for (int i = 0; i < N; i++) begin
        int unsigned j;
        j = (m_ptr + i) % N;
        if (!found && pend[j]) begin
          found = 1;
          win   = j;
        end
      end
      if (found) exp_ready[win] = 1'b1;
    end
    check("req_ready",  32'(req_ready),  32'(exp_ready));
    check("resp_valid", 32'(resp_valid), 32'(exp_resp));
    check("busy",       32'(busy),       32'(exp_busy));
    check("buzz_I",     32'(buzz_I),     32'(m_buzzI));
    check("resp_O",     32'(resp_O),     32'(m_respO));
    if (m_act && m_k == L + 2) m_ptr = (m_g + 1) % N;
    if (found) begin
      m_act   = 1;
      m_k     = 0;
      m_g     = win;
      m_data  = dat[win];
      m_buzzI = dat[win];
      pend[win] = 1'b0;
    end
    if (m_act) m_k++;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    for (int i = 0; i < N; i++) dat[i] = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    check("rst_req_ready",  32'(req_ready),  32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_buzz_I",     32'(buzz_I),     32'd0);
    check("rst_resp_O",     32'(resp_O),     32'd0);
    @(negedge CLK);
    ASYNCRESETN = 1'b1;

    // Random traffic with occasional withdrawals.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          dat[i]  = W'($urandom);
        end else if (pend[i] && $urandom_range(0, 9) == 0) begin
          pend[i] = 1'b0;
        end
      end
      drive();
      cycle();
    end

    // Drain, then complete one from requester 0 so the pointer sits at 1.
    pend = '0;
    repeat (L + 4) begin drive(); cycle(); end
    pend = 3'b001;
    dat[0] = 8'h3C;
    repeat (L + 4) begin drive(); cycle(); end

    // Accept requester 2, then abort with reset during WAIT.
    pend = 3'b100;
    dat[2] = 8'hC5;
    drive(); cycle();
    drive(); cycle();
    pend = '0;
    drive();
    ASYNCRESETN = 1'b0;
    #1;
    check("abort_busy",       32'(busy),       32'd0);
    check("abort_buzz_I",     32'(buzz_I),     32'd0);
    check("abort_resp_O",     32'(resp_O),     32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    m_act = 0; m_k = 0; m_ptr = 0; m_buzzI = '0; m_respO = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("abort_hold_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_hold_busy",       32'(busy),       32'd0);
    ASYNCRESETN = 1'b1;

    // All requesters held high: grants must rotate 0,1,2,0 from a fresh pointer.
    repeat (4 * (L + 3) + 2) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          pend[i] = 1'b1;
          dat[i]  = W'($urandom);
        end
      end
      drive();
      cycle();
    end

    pend = '0;
    repeat (L + 4) begin drive(); cycle(); end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
